// File: rtl/xc_malu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide ALU: op codes, FSM states, step modes.
// No logic; constants and a width helper only.
// Not applicable.
package xc_malu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULHSU = 3'd1;
    localparam logic [2:0] OP_MULU   = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_DIVU   = 3'd4;
    localparam logic [2:0] OP_CLMUL  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_CALC = 4'b0010,
        S_FIX  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_DIV   = 2'd1,
        MD_CLMUL = 2'd2
    } mode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/xc_malu_mdr_gen_if.sv
// Operand/result handshake bundle between the execute stage and the multiply/divide unit.
// Pure wiring, zero latency.
// valid/ready on both the request and the result side.
interface xc_malu_mdr_gen_if #(
    parameter int XLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          op;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                out_valid;
    logic                out_ready;
    logic [2*XLEN-1:0]   result;

    modport master (
        output in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/xc_malu_mdr_step.sv
// One CALC iteration: MUL_STEP-bit shift-add multiply, 1-bit restoring divide, optional clmul.
// Purely combinational, zero latency.
// None; the caller decides when the result is registered.
module xc_malu_mdr_step
    import xc_malu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  mode_t             mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt
);
    localparam int PW = XLEN + MUL_STEP;

    logic [MUL_STEP-1:0] digit;
    logic [PW-1:0]       pp_add;
    logic [PW-1:0]       sum_add;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       rem_sh;
    logic                rem_ge;
    logic [XLEN-1:0]     rem_new;
    logic [2*XLEN-1:0]   div_nxt;
`ifdef XC_MALU_CLMUL_EN
    logic [PW-1:0]       pp_xor;
    logic [PW-1:0]       sum_xor;
    logic [2*XLEN-1:0]   clm_nxt;
`endif

    // Multiplier sits in the low half and is shifted out as product bits shift in.
    always_comb begin
        digit  = acc[MUL_STEP-1:0];
        pp_add = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (digit[i]) pp_add = pp_add + (PW'(opnd) << i);
        sum_add = PW'(acc[2*XLEN-1:XLEN]) + pp_add;
        mul_nxt = {sum_add, acc[XLEN-1:MUL_STEP]};
`ifdef XC_MALU_CLMUL_EN
        pp_xor = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (digit[i]) pp_xor = pp_xor ^ (PW'(opnd) << i);
        sum_xor = PW'(acc[2*XLEN-1:XLEN]) ^ pp_xor;
        clm_nxt = {sum_xor, acc[XLEN-1:MUL_STEP]};
`endif
    end

    // Remainder in the high half, dividend/quotient shifting through the low half.
    always_comb begin
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, opnd};
        rem_new = rem_ge ? (rem_sh[XLEN-1:0] - opnd) : rem_sh[XLEN-1:0];
        div_nxt = {rem_new, acc[XLEN-2:0], rem_ge};
    end

    always_comb begin
        case (mode)
            MD_DIV:   acc_nxt = div_nxt;
`ifdef XC_MALU_CLMUL_EN
            MD_CLMUL: acc_nxt = clm_nxt;
`endif
            default:  acc_nxt = mul_nxt;
        endcase
    end

endmodule

// File: rtl/xc_malu_mdr_gen.sv
// Constant-time multiply / divide / remainder over XLEN; XC_MALU_CLMUL_EN adds carry-less multiply.
// Latency N+1 cycles from accept (N = XLEN/MUL_STEP multiply, XLEN divide), data independent.
// in_ready only in IDLE; result held in DONE until out_ready; flush/reset scrub with flush_data.
module xc_malu_mdr_gen
    import xc_malu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_data,
    xc_malu_mdr_gen_if.slave bus
);
    localparam int            CW       = clog2(XLEN);
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_step, fix_res;
    logic [XLEN-1:0]   opnd, rs1_q;
    mode_t             mode_q, mode_in;
    logic              zero_q, prod_neg_q, quot_neg_q, rem_neg_q, div0_q, ovf_q;
    logic              zero_in, prod_neg_in, quot_neg_in, rem_neg_in, div0_in, ovf_in;
    logic              s1, s2, accept, calc_last;
    logic [XLEN-1:0]   mag1, mag2, quo, rem;

    always_comb begin
        mode_in = MD_MUL;
        zero_in = 1'b0;
        s1      = 1'b0;
        s2      = 1'b0;
        case (bus.op)
            OP_MUL:    begin s1 = bus.rs1[XLEN-1]; s2 = bus.rs2[XLEN-1]; end
            OP_MULHSU: s1 = bus.rs1[XLEN-1];
            OP_MULU:   ;
            OP_DIV:    begin mode_in = MD_DIV; s1 = bus.rs1[XLEN-1]; s2 = bus.rs2[XLEN-1]; end
            OP_DIVU:   mode_in = MD_DIV;
`ifdef XC_MALU_CLMUL_EN
            OP_CLMUL:  mode_in = MD_CLMUL;
`endif
            default:   zero_in = 1'b1;
        endcase
        mag1        = s1 ? -bus.rs1 : bus.rs1;
        mag2        = s2 ? -bus.rs2 : bus.rs2;
        div0_in     = (mode_in == MD_DIV) && (bus.rs2 == '0);
        ovf_in      = (bus.op == OP_DIV) && (bus.rs1 == MOST_NEG) && (&bus.rs2);
        prod_neg_in = (mode_in == MD_MUL) && (s1 ^ s2);
        quot_neg_in = (mode_in == MD_DIV) && (s1 ^ s2) && !div0_in;
        rem_neg_in  = (mode_in == MD_DIV) && s1;
    end

    assign calc_last = (cnt == ((mode_q == MD_DIV) ? DIV_LAST : MUL_LAST));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: if (calc_last) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    xc_malu_mdr_step #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) u_step (
        .mode    (mode_q),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_step)
    );

    // Special cases override the arithmetic result rather than shortcutting it, keeping timing flat.
    always_comb begin
        quo = acc[XLEN-1:0];
        rem = acc[2*XLEN-1:XLEN];
        if (quot_neg_q) quo = -quo;
        if (rem_neg_q)  rem = -rem;
        if (div0_q) begin
            quo = '1;
            rem = rs1_q;
        end else if (ovf_q) begin
            quo = rs1_q;
            rem = '0;
        end
        if (zero_q)                fix_res = '0;
        else if (mode_q == MD_DIV) fix_res = {rem, quo};
        else if (prod_neg_q)       fix_res = -acc;
        else                       fix_res = acc;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            cnt        <= '0;
            acc        <= {flush_data, flush_data};
            opnd       <= flush_data;
            rs1_q      <= flush_data;
            mode_q     <= MD_MUL;
            zero_q     <= 1'b0;
            prod_neg_q <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            acc        <= (mode_in == MD_DIV) ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            opnd       <= (mode_in == MD_DIV) ? mag2 : mag1;
            rs1_q      <= bus.rs1;
            mode_q     <= mode_in;
            zero_q     <= zero_in;
            prod_neg_q <= prod_neg_in;
            quot_neg_q <= quot_neg_in;
            rem_neg_q  <= rem_neg_in;
            div0_q     <= div0_in;
            ovf_q      <= ovf_in;
        end else if (state == S_CALC) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
        end else if (state == S_FIX) begin
            acc <= fix_res;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = bus.out_valid ? acc : '0;

endmodule

// File: tb/tb_xc_malu_mdr_gen.sv
// Scoreboard bench for xc_malu_mdr_gen: a 32-bit/4-step and a 64-bit/8-step instance,
// directed vectors queued at issue and checked (value, latency, stability) by per-instance monitors.
module tb_xc_malu_mdr_gen;
    import xc_malu_pkg::*;

    typedef struct {
        logic [127:0] res;
        int           cyc;
        string        nm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush32, flush64;
    logic [31:0] fd32;
    logic [63:0] fd64;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    exp_t        q32[$];
    exp_t        q64[$];
    exp_t        e32, e64;
    bit          seen32 = 0, seen64 = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    xc_malu_mdr_gen_if #(.XLEN(32)) bus32();
    xc_malu_mdr_gen_if #(.XLEN(64)) bus64();

    xc_malu_mdr_gen #(.XLEN(32), .MUL_STEP(4)) dut32 (
        .clock(clock), .reset(reset), .flush(flush32), .flush_data(fd32), .bus(bus32));
    xc_malu_mdr_gen #(.XLEN(64), .MUL_STEP(8)) dut64 (
        .clock(clock), .reset(reset), .flush(flush64), .flush_data(fd64), .bus(bus64));

    localparam logic [127:0] CLM33 =
`ifdef XC_MALU_CLMUL_EN
        128'h5;
`else
        128'h0;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reset or flush discards whatever the instance still owed.
    always @(posedge clock) begin
        if (reset || flush32) begin q32.delete(); seen32 = 0; end
        if (reset || flush64) begin q64.delete(); seen64 = 0; end
    end

    always @(negedge clock) begin
        if (bus32.out_valid !== 1'b1) begin
            nchk++;
            if (bus32.result !== '0) begin
                nerr++;
                $display("FAIL idle_result32: got %h expected 0", bus32.result);
            end
            seen32 = 0;
        end else if (q32.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected32: got result %h with nothing expected", bus32.result);
        end else begin
            e32 = q32[0];
            if (!seen32) begin
                nchk++;
                if (cyc != e32.cyc) begin
                    nerr++;
                    $display("FAIL lat32 %s: valid at cycle %0d expected %0d", e32.nm, cyc, e32.cyc);
                end
                seen32 = 1;
            end
            nchk++;
            if ({64'b0, bus32.result} !== e32.res) begin
                nerr++;
                $display("FAIL res32 %s: got %h expected %h", e32.nm, bus32.result, e32.res[63:0]);
            end
            if (bus32.out_ready) begin void'(q32.pop_front()); seen32 = 0; end
        end
    end

    always @(negedge clock) begin
        if (bus64.out_valid !== 1'b1) begin
            nchk++;
            if (bus64.result !== '0) begin
                nerr++;
                $display("FAIL idle_result64: got %h expected 0", bus64.result);
            end
            seen64 = 0;
        end else if (q64.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected64: got result %h with nothing expected", bus64.result);
        end else begin
            e64 = q64[0];
            if (!seen64) begin
                nchk++;
                if (cyc != e64.cyc) begin
                    nerr++;
                    $display("FAIL lat64 %s: valid at cycle %0d expected %0d", e64.nm, cyc, e64.cyc);
                end
                seen64 = 1;
            end
            nchk++;
            if (bus64.result !== e64.res) begin
                nerr++;
                $display("FAIL res64 %s: got %h expected %h", e64.nm, bus64.result, e64.res);
            end
            if (bus64.out_ready) begin void'(q64.pop_front()); seen64 = 0; end
        end
    end

    // Callers sit 1 time unit after a rising edge; the accept lands on the next edge.
    task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input string nm);
        int t;
        exp_t e;
        t = 0;
        while (bus32.in_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        if (bus32.in_ready !== 1'b1) begin
            nchk++; nerr++;
            $display("FAIL issue32 %s: in_ready never rose, got %b expected 1", nm, bus32.in_ready);
            return;
        end
        bus32.in_valid = 1'b1; bus32.op = o; bus32.rs1 = a; bus32.rs2 = b;
        e.res = {64'b0, exp}; e.cyc = cyc + lat + 1; e.nm = nm;
        q32.push_back(e);
        @(posedge clock); #1;
        bus32.in_valid = 1'b0; bus32.op = 3'd7; bus32.rs1 = 32'hDEADBEEF; bus32.rs2 = 32'hCAFEF00D;
    endtask

    task automatic issue64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                           input logic [127:0] exp, input int lat, input string nm);
        int t;
        exp_t e;
        t = 0;
        while (bus64.in_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        if (bus64.in_ready !== 1'b1) begin
            nchk++; nerr++;
            $display("FAIL issue64 %s: in_ready never rose, got %b expected 1", nm, bus64.in_ready);
            return;
        end
        bus64.in_valid = 1'b1; bus64.op = o; bus64.rs1 = a; bus64.rs2 = b;
        e.res = exp; e.cyc = cyc + lat + 1; e.nm = nm;
        q64.push_back(e);
        @(posedge clock); #1;
        bus64.in_valid = 1'b0; bus64.op = 3'd7; bus64.rs1 = '1; bus64.rs2 = '1;
    endtask

    task automatic wait_valid32(input string nm);
        int t;
        t = 0;
        while (bus32.out_valid !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        chk(nm, {127'b0, bus32.out_valid}, 128'd1);
    endtask

    initial begin
        int t;
        reset = 1'b1; flush32 = 1'b0; flush64 = 1'b0;
        fd32 = 32'h5A5A5A5A; fd64 = 64'h5A5A5A5A_5A5A5A5A;
        bus32.in_valid = 1'b0; bus32.op = '0; bus32.rs1 = '0; bus32.rs2 = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.op = '0; bus64.rs1 = '0; bus64.rs2 = '0; bus64.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1; reset = 1'b0;
        chk("rst_in_ready32",  {127'b0, bus32.in_ready},  128'd1);
        chk("rst_out_valid32", {127'b0, bus32.out_valid}, 128'd0);
        chk("rst_result32",    {64'b0, bus32.result},     128'd0);
        chk("rst_in_ready64",  {127'b0, bus64.in_ready},  128'd1);

        // Multiply result held through three stalled cycles.
        bus32.out_ready = 1'b0;
        issue32(OP_MUL, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 9, "mul_neg");
        wait_valid32("stall_valid32");
        repeat (3) begin @(posedge clock); #1; end
        bus32.out_ready = 1'b1;

        issue32(OP_DIV,    32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, "div_neg");
        issue32(OP_DIVU,   32'd100,      32'd0,        64'h00000064_FFFFFFFF, 33, "divu_zero");
        issue32(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, "div_ovf");
        issue32(OP_DIV,    32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 33, "div_zero_neg");
        issue32(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        64'hFFFFFFFF_FFFFFFFE, 9,  "mulhsu");
        issue32(3'd6,      32'd5,        32'd6,        64'h0,                 9,  "rsvd6");
        issue32(3'd7,      32'hFFFF,     32'hFFFF,     64'h0,                 9,  "rsvd7");
        issue32(OP_CLMUL,  32'd3,        32'd3,        CLM33[63:0],           9,  "clmul32");

        // Flush in the middle of CALC drops the pending product.
        issue32(OP_MULU, 32'h1234, 32'd5, 64'h5B04, 9, "flushed");
        repeat (3) begin @(posedge clock); #1; end
        flush32 = 1'b1; fd32 = 32'hA5A5A5A5;
        @(posedge clock); #1;
        flush32 = 1'b0;
        chk("flush_in_ready32",  {127'b0, bus32.in_ready},  128'd1);
        chk("flush_out_valid32", {127'b0, bus32.out_valid}, 128'd0);
        repeat (12) begin @(posedge clock); #1; end

        issue32(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 9, "mulu_max");

        // Flush coinciding with an accept: operation is dropped.
        t = 0;
        while (bus32.in_ready !== 1'b1 && t < 200) begin @(posedge clock); #1; t++; end
        bus32.in_valid = 1'b1; bus32.op = OP_MULU; bus32.rs1 = 32'd3; bus32.rs2 = 32'd3;
        flush32 = 1'b1;
        @(posedge clock); #1;
        bus32.in_valid = 1'b0; flush32 = 1'b0;
        chk("flush_accept_in_ready32", {127'b0, bus32.in_ready}, 128'd1);
        repeat (12) begin @(posedge clock); #1; end

        // in_valid during CALC must neither be taken nor disturb the running divide.
        issue32(OP_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142}, 33, "divu_busy");
        bus32.in_valid = 1'b1; bus32.op = OP_MUL; bus32.rs1 = 32'd5; bus32.rs2 = 32'd5;
        repeat (5) begin @(posedge clock); #1; end
        bus32.in_valid = 1'b0;

        issue64(OP_MUL,    64'h1_0000_0000, 64'h1_0000_0000, {64'h1, 64'h0}, 9, "mul64_carry");
        issue64(OP_MULHSU, '1,              64'd2,
                128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE, 9, "mulhsu64");
        issue64(OP_DIVU,   64'd1000,        64'd7,           {64'd6, 64'd142}, 65, "divu64");
        issue64(OP_DIV,    64'hFFFFFFFF_FFFFFFF9, 64'd2,
                128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFD, 65, "div64_neg");
        issue64(OP_CLMUL,  64'd3,           64'd3,           CLM33, 9, "clmul64");

        t = 0;
        while ((q32.size() != 0 || q64.size() != 0) && t < 400) begin @(posedge clock); #1; t++; end
        chk("drain32", 128'(q32.size()), 128'd0);
        chk("drain64", 128'(q64.size()), 128'd0);

        // Reset while a result is waiting in DONE.
        bus32.out_ready = 1'b0;
        issue32(OP_MUL, 32'd3, 32'd4, 64'd12, 9, "mul_then_reset");
        wait_valid32("reset_done_valid32");
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus32.out_ready = 1'b1;
        chk("done_reset_out_valid32", {127'b0, bus32.out_valid}, 128'd0);
        chk("done_reset_in_ready32",  {127'b0, bus32.in_ready},  128'd1);
        chk("done_reset_result32",    {64'b0, bus32.result},     128'd0);
        repeat (4) begin @(posedge clock); #1; end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
